// File: rtl/redux_pkg.sv
// rtl/redux_pkg.sv - shared types and default address map for the instruction fetch controller
// Contents: estado_t (fetch FSM states) and the default program base/end addresses.
package redux_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        BUSCA   = 2'd1,
        ENTREGA = 2'd2,
        FIM     = 2'd3
    } estado_t;

    // Default program map: each end address is exclusive (never fetched).
    localparam logic [7:0] BASE_ALG1_PAD = 8'd0;
    localparam logic [7:0] FIM_ALG1_PAD  = 8'd40;
    localparam logic [7:0] BASE_ALG2_PAD = 8'd41;
    localparam logic [7:0] FIM_ALG2_PAD  = 8'd101;

    localparam int CONTADOR_W = 16;

endpackage

// File: rtl/contador_programa.sv
// rtl/contador_programa.sv - program counter with start load, increment, branch load and limit compare
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   carregar             load pc with base and latch limite_novo as the limit
//   base, limite_novo    start address and exclusive end address for the load
//   avancar              accepted handshake: pc takes the next address
//   desvio_valido/alvo   branch request, only used when avancar is high
//   pc                   current fetch address
//   atinge_limite        the next address (branch or pc+1) equals the latched limit
module contador_programa
    import redux_pkg::*;
#(
    parameter logic [7:0] LIMITE_RESET = FIM_ALG1_PAD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carregar,
    input  logic [7:0] base,
    input  logic [7:0] limite_novo,
    input  logic       avancar,
    input  logic       desvio_valido,
    input  logic [7:0] desvio_alvo,
    output logic [7:0] pc,
    output logic       atinge_limite
);

    logic [7:0] limite;
    logic [7:0] proximo;

    // Branch wins over the sequential step; the 8-bit add wraps FF -> 00.
    assign proximo = desvio_valido ? desvio_alvo : pc + 8'd1;

    // Only the advance path is compared, so a start load equal to the limit
    // never ends the program by itself.
    assign atinge_limite = (proximo == limite);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc     <= 8'd0;
            limite <= LIMITE_RESET;
        end else if (carregar) begin
            pc     <= base;
            limite <= limite_novo;
        end else if (avancar) begin
            pc     <= proximo;
        end
    end

endmodule

// File: rtl/controle_busca.sv
// rtl/controle_busca.sv - instruction fetch controller: fetches a program window and hands words to a consumer
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   iniciar, programa_sel start pulse and program select (taken only in OCIOSO or FIM)
//   instrucao_in          memory word for endereco (combinational memory)
//   pronto                consumer accepts instrucao_out this cycle
//   desvio_valido/alvo    branch taken and its target, used on an accepted handshake
//   endereco              fetch address to the instruction memory
//   instrucao_out         registered instruction word
//   instrucao_valida      instrucao_out holds an unconsumed instruction
//   ocupado, fim          busy (BUSCA/ENTREGA) and finished (FIM) flags
//   contador              accepted-handshake count, present only with BUSCA_CONTADOR_EN
module controle_busca
    import redux_pkg::*;
#(
    parameter logic [7:0] BASE_ALG1 = BASE_ALG1_PAD,
    parameter logic [7:0] FIM_ALG1  = FIM_ALG1_PAD,
    parameter logic [7:0] BASE_ALG2 = BASE_ALG2_PAD,
    parameter logic [7:0] FIM_ALG2  = FIM_ALG2_PAD
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iniciar,
    input  logic                  programa_sel,
    input  logic [7:0]            instrucao_in,
    input  logic                  pronto,
    input  logic                  desvio_valido,
    input  logic [7:0]            desvio_alvo,
    output logic [7:0]            endereco,
    output logic [7:0]            instrucao_out,
    output logic                  instrucao_valida,
    output logic                  ocupado,
    output logic                  fim
`ifdef BUSCA_CONTADOR_EN
    ,
    output logic [CONTADOR_W-1:0] contador
`endif
);

    estado_t    estado, estado_prox;
    logic       aceita_inicio;
    logic       aceita_entrega;
    logic       atinge_limite;
    logic [7:0] base_sel;
    logic [7:0] limite_sel;

    assign aceita_inicio  = iniciar && (estado == OCIOSO || estado == FIM);
    assign aceita_entrega = (estado == ENTREGA) && pronto;
    assign base_sel       = programa_sel ? BASE_ALG2 : BASE_ALG1;
    assign limite_sel     = programa_sel ? FIM_ALG2  : FIM_ALG1;

    contador_programa #(
        .LIMITE_RESET (FIM_ALG1)
    ) u_pc (
        .clock         (clock),
        .reset         (reset),
        .carregar      (aceita_inicio),
        .base          (base_sel),
        .limite_novo   (limite_sel),
        .avancar       (aceita_entrega),
        .desvio_valido (desvio_valido),
        .desvio_alvo   (desvio_alvo),
        .pc            (endereco),
        .atinge_limite (atinge_limite)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO:  if (aceita_inicio) estado_prox = BUSCA;
            BUSCA:   estado_prox = ENTREGA;
            ENTREGA: if (pronto) estado_prox = atinge_limite ? FIM : BUSCA;
            FIM:     if (aceita_inicio) estado_prox = BUSCA;
            default: estado_prox = OCIOSO;
        endcase
    end

    // The word is captured only in BUSCA, so it stays frozen while the
    // consumer stalls in ENTREGA.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instrucao_out <= 8'd0;
        end else if (estado == BUSCA) begin
            instrucao_out <= instrucao_in;
        end
    end

    // Valid is exactly "sitting in ENTREGA": it rises one cycle after the
    // fetch address is presented and falls the cycle after acceptance.
    assign instrucao_valida = (estado == ENTREGA);
    assign ocupado          = (estado == BUSCA) || (estado == ENTREGA);
    assign fim              = (estado == FIM);

`ifdef BUSCA_CONTADOR_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador <= '0;
        end else if (aceita_inicio) begin
            contador <= '0;
        end else if (aceita_entrega && contador != {CONTADOR_W{1'b1}}) begin
            contador <= contador + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_controle_busca.sv
// tb/tb_controle_busca.sv - self-checking bench for controle_busca
module tb_controle_busca;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       programa_sel;
    logic       pronto;
    logic       desvio_valido;
    logic [7:0] desvio_alvo;

    logic [7:0] instr_a, instr_w;
    logic [7:0] endereco, instrucao_out, w_endereco, w_instrucao_out;
    logic       instrucao_valida, ocupado, fim;
    logic       w_valida, w_ocupado, w_fim;
`ifdef BUSCA_CONTADOR_EN
    logic [15:0] contador, w_contador;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Bijective memory contents so every address returns a distinct word.
    function automatic logic [7:0] mem(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'h3C;
    endfunction

    assign instr_a = mem(endereco);
    assign instr_w = mem(w_endereco);

    controle_busca dut (
        .clock            (clock),
        .reset            (reset),
        .iniciar          (iniciar),
        .programa_sel     (programa_sel),
        .instrucao_in     (instr_a),
        .pronto           (pronto),
        .desvio_valido    (desvio_valido),
        .desvio_alvo      (desvio_alvo),
        .endereco         (endereco),
        .instrucao_out    (instrucao_out),
        .instrucao_valida (instrucao_valida),
        .ocupado          (ocupado),
        .fim              (fim)
`ifdef BUSCA_CONTADOR_EN
        ,
        .contador         (contador)
`endif
    );

    // Second instance with program 1 placed across the address wrap.
    controle_busca #(
        .BASE_ALG2 (8'hFE),
        .FIM_ALG2  (8'd2)
    ) dut_w (
        .clock            (clock),
        .reset            (reset),
        .iniciar          (iniciar),
        .programa_sel     (programa_sel),
        .instrucao_in     (instr_w),
        .pronto           (pronto),
        .desvio_valido    (desvio_valido),
        .desvio_alvo      (desvio_alvo),
        .endereco         (w_endereco),
        .instrucao_out    (w_instrucao_out),
        .instrucao_valida (w_valida),
        .ocupado          (w_ocupado),
        .fim              (w_fim)
`ifdef BUSCA_CONTADOR_EN
        ,
        .contador         (w_contador)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; iniciar = 1'b0; programa_sel = 1'b0;
        pronto = 1'b0; desvio_valido = 1'b0; desvio_alvo = 8'd0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic start(input logic sel);
        iniciar = 1'b1; programa_sel = sel;
        tick();
        iniciar = 1'b0; programa_sel = 1'($urandom_range(0, 1));
    endtask

    // Transaction-level model: the PC walks base..limit-1 (or jumps forward
    // on a branch), one fetch cycle plus one-or-more delivery cycles each.
    task automatic run_prog(input logic sel, input bit rnd, output int hs);
        logic [7:0] pc, lim;
        int cyc;
        bit no_limite;
        pc = sel ? 8'd41 : 8'd0;
        lim = sel ? 8'd101 : 8'd40;
        hs = 0; no_limite = 0;
        start(sel);
        chk("first_addr", endereco, pc);
        for (cyc = 0; cyc < 3000 && !no_limite; cyc++) begin
            // fetch cycle: junk on handshake inputs must be ignored
            chk("fetch_addr", endereco, pc);
            chk("fetch_valid", instrucao_valida, 0);
            chk("busy", ocupado, 1);
            pronto = 1'($urandom_range(0, 1));
            desvio_valido = 1'($urandom_range(0, 1));
            desvio_alvo = 8'($urandom);
            tick();
            forever begin
                chk("deliver_word", instrucao_out, mem(pc));
                chk("deliver_addr", endereco, pc);
                chk("deliver_valid", instrucao_valida, 1);
                pronto = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                desvio_valido = 1'b0;
                desvio_alvo = 8'($urandom);
                if (!pronto) desvio_valido = 1'($urandom_range(0, 1));
                else if (rnd && $urandom_range(0, 4) == 0) begin
                    desvio_valido = 1'b1;
                    desvio_alvo = 8'($urandom_range(pc + 1, lim));
                end
                tick();
                cyc++;
                if (pronto || cyc > 3000) break;
            end
            hs++;
            pc = desvio_valido ? desvio_alvo : pc + 8'd1;
            no_limite = (pc == lim);
        end
        pronto = 1'b0; desvio_valido = 1'b0;
        chk("prog_terminated", no_limite, 1);
        chk("end_fim", fim, 1);
        chk("end_addr", endereco, lim);
        chk("end_valid", instrucao_valida, 0);
`ifdef BUSCA_CONTADOR_EN
        chk("contador", contador, hs);
`endif
    endtask

    // Step a fresh program-0 run until it is delivering the word at `alvo`.
    task automatic walk_to(input logic [7:0] alvo);
        logic [7:0] pc = 8'd0;
        pronto = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pronto = 1'b0;
            tick();
            if (pc == alvo) break;
            pronto = 1'b1;
            tick();
            pc++;
        end
        pronto = 1'b0;
        chk("walk_addr", endereco, alvo);
    endtask

    typedef struct {
        logic       sel;
        int         exp_hs;
    } prog_vec_t;

    typedef struct {
        logic [7:0] at;
        logic [7:0] alvo;
        logic [7:0] exp_addr;
        logic       exp_fim;
    } desvio_vec_t;

    prog_vec_t   progs[2];
    desvio_vec_t desvios[2];
    logic [7:0]  wrap_seq[4];

    initial begin
        int hs;
        progs[0]   = '{sel: 1'b0, exp_hs: 40};
        progs[1]   = '{sel: 1'b1, exp_hs: 60};
        desvios[0] = '{at: 8'd10, alvo: 8'd30, exp_addr: 8'd30, exp_fim: 1'b0};
        desvios[1] = '{at: 8'd10, alvo: 8'd40, exp_addr: 8'd40, exp_fim: 1'b1};
        wrap_seq   = '{8'hFE, 8'hFF, 8'h00, 8'h01};

        // reset state
        do_reset();
        chk("rst_addr", endereco, 0);
        chk("rst_word", instrucao_out, 0);
        chk("rst_valid", instrucao_valida, 0);
        chk("rst_busy", ocupado, 0);
        chk("rst_fim", fim, 0);

        // full programs with pronto held high; program 1 restarts from FIM
        foreach (progs[i]) begin
            run_prog(progs[i].sel, 1'b0, hs);
            chk("handshakes", hs, progs[i].exp_hs);
        end

        // randomized handshake/branch runs against the model
        for (int r = 0; r < 6; r++) run_prog(1'(r % 2), 1'b1, hs);

        // branch vectors
        foreach (desvios[i]) begin
            do_reset();
            start(1'b0);
            walk_to(desvios[i].at);
            pronto = 1'b1; desvio_valido = 1'b1; desvio_alvo = desvios[i].alvo;
            tick();
            pronto = 1'b0; desvio_valido = 1'b0;
            chk("branch_addr", endereco, desvios[i].exp_addr);
            chk("branch_fim", fim, desvios[i].exp_fim);
        end

        // stall in ENTREGA for 5 cycles, then release
        do_reset();
        start(1'b0);
        tick();
        pronto = 1'b0;
        for (int i = 0; i < 5; i++) begin
            desvio_valido = 1'b1; desvio_alvo = 8'd33;
            tick();
            chk("stall_addr", endereco, 0);
            chk("stall_word", instrucao_out, mem(8'd0));
            chk("stall_valid", instrucao_valida, 1);
        end
        pronto = 1'b1; desvio_valido = 1'b0;
        tick();
        pronto = 1'b0;
        chk("release_addr", endereco, 1);
        chk("release_valid", instrucao_valida, 0);

        // iniciar during BUSCA is ignored
        do_reset();
        start(1'b0);
        iniciar = 1'b1; programa_sel = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("ign_start_addr", endereco, 0);
        chk("ign_start_valid", instrucao_valida, 1);
        pronto = 1'b1;
        tick();
        pronto = 1'b0;
        chk("ign_start_next", endereco, 1);

        // asynchronous reset in the middle of ENTREGA
        do_reset();
        start(1'b0);
        walk_to(8'd3);
        #2 reset = 1'b1;
        #1;
        chk("arst_addr", endereco, 0);
        chk("arst_word", instrucao_out, 0);
        chk("arst_valid", instrucao_valida, 0);
        chk("arst_busy", ocupado, 0);
        chk("arst_fim", fim, 0);
        tick();
        reset = 1'b0;
        start(1'b0);
        chk("arst_restart", endereco, 0);

        // program window wrapping through FF -> 00
        do_reset();
        pronto = 1'b1;
        start(1'b1);
        pronto = 1'b1;
        foreach (wrap_seq[i]) begin
            chk("wrap_addr", w_endereco, wrap_seq[i]);
            chk("wrap_fetch_valid", w_valida, 0);
            tick();
            chk("wrap_word", w_instrucao_out, mem(wrap_seq[i]));
            chk("wrap_valid", w_valida, 1);
            tick();
        end
        pronto = 1'b0;
        chk("wrap_fim", w_fim, 1);
        chk("wrap_end_addr", w_endereco, 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
